// File: rtl/pow2_arb_pkg.sv
// Shared types and constants for the pow2 LUT arbiter slice.
// Holds the fraction widths, the requester-index width helper, and the
// pipeline entry layout used by both pipeline stages.
package pow2_arb_pkg;

    localparam int LOG_FRAC_BITS = 4;
    localparam int LIN_FRAC_BITS = 5;
    localparam int DEF_TAG_BITS  = 8;
    localparam int MAX_REQ       = 16;
    localparam int MAX_ID_BITS   = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_bits_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Stage 1 keeps the log fraction in the low bits of 'data'.
    // Stage 2 keeps the linear fraction in 'data'.
    typedef struct packed {
        logic [MAX_ID_BITS-1:0]   id;
        logic [DEF_TAG_BITS-1:0]  tag;
        logic [LIN_FRAC_BITS-1:0] data;
    } pipe_entry_t;

endpackage

// File: rtl/pow2_lut_arbiter_if.sv
// Request/response bundle between the PE lanes and the shared pow2 LUT.
// 'master' is the requester/consumer side, and 'slave' is the arbiter.
interface pow2_lut_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int TAG_BITS = 8
);
    localparam int ID_BITS = pow2_arb_pkg::id_bits_f(NUM_REQ);

    logic [NUM_REQ-1:0]                                  req_valid;
    logic [NUM_REQ-1:0]                                  req_ready;
    logic [NUM_REQ-1:0][pow2_arb_pkg::LOG_FRAC_BITS-1:0] req_frac;
    logic [NUM_REQ-1:0][TAG_BITS-1:0]                    req_tag;
    logic                                                resp_valid;
    logic                                                resp_ready;
    logic [ID_BITS-1:0]                                  resp_id;
    logic [pow2_arb_pkg::LIN_FRAC_BITS-1:0]              resp_lin;
    logic [TAG_BITS-1:0]                                 resp_tag;

    modport master (
        output req_valid, req_frac, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_lin, resp_tag
    );

    modport slave (
        input  req_valid, req_frac, req_tag, resp_ready,
        output req_ready, resp_valid, resp_id, resp_lin, resp_tag
    );

endinterface

// File: rtl/Pow2LUT_4x5.sv
// Combinational 4-bit log fraction to 5-bit linear fraction table.
// Output approximates 32 * (2^(frac/16) - 1).
module Pow2LUT_4x5 (
    input  logic [3:0] frac,
    output logic [4:0] lin
);

    // Table lookup.
    always_comb begin
        // NOTE: a default arm assigns 'lin' on every path, so no latch is inferred.
        unique case (frac)
            4'd0:    lin = 5'b00000;
            4'd1:    lin = 5'b00001;
            4'd2:    lin = 5'b00011;
            4'd3:    lin = 5'b00100;
            4'd4:    lin = 5'b00110;
            4'd5:    lin = 5'b01000;
            4'd6:    lin = 5'b01001;
            4'd7:    lin = 5'b01011;
            4'd8:    lin = 5'b01101;
            4'd9:    lin = 5'b01111;
            4'd10:   lin = 5'b10001;
            4'd11:   lin = 5'b10100;
            4'd12:   lin = 5'b10110;
            4'd13:   lin = 5'b11000;
            4'd14:   lin = 5'b11011;
            default: lin = 5'b11101;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// The search starts at the pointer and wraps around.
// After a grant, the pointer moves to the slot just past the winner.
// The grant is forced to zero while 'en' is low.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = pow2_arb_pkg::id_bits_f(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx
);

    logic [IDW-1:0] ptr;
    logic           found;

    // Pick the first request at or above the pointer, then wrap to below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (en) begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!found && req[i] && ((pass == 0) == (i >= int'(ptr)))) begin
                        found     = 1'b1;
                        grant[i]  = 1'b1;
                        grant_idx = IDW'(i);
                    end
                end
            end
        end
    end

    // Advance the pointer past the winner; hold it when nothing is granted.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments, so every flop samples pre-edge values.
        if (reset) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pow2_lut_arbiter.sv
// Shares one Pow2LUT_4x5 between NUM_REQ requesters.
// Round-robin grant feeds a 2-stage pipeline (s1: accepted request,
// s2: LUT result), which drives a single tagged response stream.
// Optional: define POW2_ARB_PERF_EN to add per-requester grant counters and
// a response stall-cycle counter.
module pow2_lut_arbiter
    import pow2_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int TAG_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    pow2_lut_arbiter_if.slave    bus
`ifdef POW2_ARB_PERF_EN
    ,
    output logic [31:0]          perf_grant_cnt [NUM_REQ],
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam int ID_BITS = id_bits_f(NUM_REQ);

    if (NUM_REQ < 1 || NUM_REQ > MAX_REQ || TAG_BITS > DEF_TAG_BITS || TAG_BITS < 1) begin : g_param_check
        $error("pow2_lut_arbiter: NUM_REQ must be 1..16 and TAG_BITS 1..8");
    end

    logic                     s1_valid;
    logic                     s2_valid;
    pipe_entry_t              s1_q;
    pipe_entry_t              s2_q;
    logic                     s1_en;
    logic                     s2_en;
    logic                     accept;
    logic [NUM_REQ-1:0]       grant;
    logic [ID_BITS-1:0]       grant_idx;
    logic [LOG_FRAC_BITS-1:0] sel_frac;
    logic [TAG_BITS-1:0]      sel_tag;
    logic [LIN_FRAC_BITS-1:0] lut_lin;

    assign s2_en  = !s2_valid || bus.resp_ready;
    assign s1_en  = !s1_valid || s2_en;
    assign accept = |grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (bus.req_valid),
        .en        (s1_en && !reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = grant;

    // One-hot mux of the granted requester's payload.
    always_comb begin
        sel_frac = '0;
        sel_tag  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_frac = bus.req_frac[i];
                sel_tag  = bus.req_tag[i];
            end
        end
    end

    Pow2LUT_4x5 u_lut (
        .frac (LOG_FRAC_BITS'(s1_q.data)),
        .lin  (lut_lin)
    );

    // Pipeline registers: s1 takes the accepted request, s2 takes the LUT result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: payload registers are reset as well, so resp_* read zero after reset.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_q.data <= LIN_FRAC_BITS'(sel_frac);
                    s1_q.tag  <= DEF_TAG_BITS'(sel_tag);
                    s1_q.id   <= MAX_ID_BITS'(grant_idx);
                end
            end
            if (s2_en) begin
                s2_valid  <= s1_valid;
                s2_q.data <= lut_lin;
                s2_q.tag  <= s1_q.tag;
                s2_q.id   <= s1_q.id;
            end
        end
    end

    assign bus.resp_valid = s2_valid;
    assign bus.resp_lin   = s2_q.data;
    assign bus.resp_tag   = TAG_BITS'(s2_q.tag);
    assign bus.resp_id    = ID_BITS'(s2_q.id);

`ifdef POW2_ARB_PERF_EN
    // Count accepts per requester and cycles where a response is held off.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) perf_grant_cnt[i] <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) perf_grant_cnt[i] <= perf_grant_cnt[i] + 32'd1;
            end
            if (s2_valid && !bus.resp_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pow2_lut_arbiter.sv
// Directed bench for pow2_lut_arbiter (NUM_REQ=4, TAG_BITS=8).
// Inputs are driven 1ns after the rising edge, and outputs are sampled 1ns later.
module tb_pow2_lut_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference table: round(32 * (2^(f/16) - 1)).
    logic [4:0] lut_ref [16] = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd6, 5'd8, 5'd9, 5'd11,
                                 5'd13, 5'd15, 5'd17, 5'd20, 5'd22, 5'd24, 5'd27, 5'd29};

    always #5 clock = ~clock;

    pow2_lut_arbiter_if #(.NUM_REQ(4), .TAG_BITS(8)) bus ();

`ifdef POW2_ARB_PERF_EN
    logic [31:0] perf_grant_cnt [4];
    logic [31:0] perf_stall_cnt;
`endif

    pow2_lut_arbiter #(.NUM_REQ(4), .TAG_BITS(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus)
`ifdef POW2_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid  = '0;
        bus.req_frac   = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.req_valid = 4'b1111;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready);
        end
        vectors++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_lin, bus.resp_tag} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_resp: got v=%b id=%0d lin=%b tag=%h want all 0",
                     bus.resp_valid, bus.resp_id, bus.resp_lin, bus.resp_tag);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_pointer: got %b want 0001", bus.req_ready);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid  = 4'b0100;
        bus.req_frac[2] = 4'b0010;
        bus.req_tag[2]  = 8'hA5;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_grant: got %b want 0100", bus.req_ready);
        end
        next_cycle();
        bus.req_valid = '0;
        #1;
        vectors++;
        if (bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: resp_valid got %b want 0", bus.resp_valid);
        end
        next_cycle();
        #1;
        vectors++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_lin, bus.resp_tag} !== {1'b1, 2'd2, 5'b00011, 8'hA5}) begin
            miscompares++;
            $display("FAIL single_resp: got v=%b id=%0d lin=%b tag=%h want v=1 id=2 lin=00011 tag=a5",
                     bus.resp_valid, bus.resp_id, bus.resp_lin, bus.resp_tag);
        end
        next_cycle();
        #1;
        vectors++;
        if (bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain: resp_valid got %b want 0", bus.resp_valid);
        end
    endtask

    task automatic test_lut_sweep();
        do_reset();
        for (int c = 0; c < 19; c++) begin
            if (c < 16) begin
                bus.req_valid   = 4'b0001;
                bus.req_frac[0] = 4'(c);
                bus.req_tag[0]  = 8'(c + 8'h40);
            end else begin
                bus.req_valid = '0;
            end
            #1;
            if (c < 16) begin
                vectors++;
                if (bus.req_ready !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL sweep_ready[%0d]: got %b want 0001", c, bus.req_ready);
                end
            end
            vectors++;
            if (c >= 2 && c < 18) begin
                if ({bus.resp_valid, bus.resp_id, bus.resp_lin, bus.resp_tag} !==
                    {1'b1, 2'd0, lut_ref[c-2], 8'(c - 2 + 8'h40)}) begin
                    miscompares++;
                    $display("FAIL sweep_resp[%0d]: got v=%b id=%0d lin=%b tag=%h want v=1 id=0 lin=%b tag=%h",
                             c - 2, bus.resp_valid, bus.resp_id, bus.resp_lin, bus.resp_tag,
                             lut_ref[c-2], 8'(c - 2 + 8'h40));
                end
            end else if (bus.resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep_idle[%0d]: resp_valid got %b want 0", c, bus.resp_valid);
            end
            next_cycle();
        end
    endtask

    task automatic test_fairness();
        int cnt [4];
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            #1;
            want = 4'b0001 << (k % 4);
            vectors++;
            if (bus.req_ready !== want) begin
                miscompares++;
                $display("FAIL fair_grant[%0d]: got %b want %b", k, bus.req_ready, want);
            end
            for (int i = 0; i < 4; i++) if (bus.req_ready[i] && bus.req_valid[i]) cnt[i]++;
            next_cycle();
        end
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cnt[i] !== 3) begin
                miscompares++;
                $display("FAIL fair_count[%0d]: got %0d want 3", i, cnt[i]);
            end
`ifdef POW2_ARB_PERF_EN
            vectors++;
            if (perf_grant_cnt[i] !== 32'd3) begin
                miscompares++;
                $display("FAIL fair_perf[%0d]: got %0d want 3", i, perf_grant_cnt[i]);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  pending;
        logic [3:0]  want_ready [12];
        logic [15:0] want_resp  [12];
        int          accepts;
        want_ready = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                       4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        want_resp  = '{16'h0000, 16'h0000,
                       {1'b1, 2'd0, 5'd8, 8'h10}, {1'b1, 2'd0, 5'd8, 8'h10},
                       {1'b1, 2'd0, 5'd8, 8'h10}, {1'b1, 2'd0, 5'd8, 8'h10},
                       {1'b1, 2'd0, 5'd8, 8'h10}, {1'b1, 2'd0, 5'd8, 8'h10},
                       {1'b1, 2'd1, 5'd9, 8'h11}, {1'b1, 2'd2, 5'd11, 8'h12},
                       {1'b1, 2'd3, 5'd13, 8'h13}, 16'h0000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_frac[i] = 4'(i + 5);
            bus.req_tag[i]  = 8'(8'h10 + i);
        end
        pending = 4'b1111;
        accepts = 0;
        for (int c = 0; c < 12; c++) begin
            bus.resp_ready = (c >= 7);
            bus.req_valid  = pending;
            #1;
            vectors++;
            if (bus.req_ready !== want_ready[c]) begin
                miscompares++;
                $display("FAIL bp_ready[%0d]: got %b want %b", c, bus.req_ready, want_ready[c]);
            end
            vectors++;
            if (want_resp[c][15]) begin
                if ({bus.resp_valid, bus.resp_id, bus.resp_lin, bus.resp_tag} !== want_resp[c]) begin
                    miscompares++;
                    $display("FAIL bp_resp[%0d]: got %h want %h", c,
                             {bus.resp_valid, bus.resp_id, bus.resp_lin, bus.resp_tag}, want_resp[c]);
                end
            end else if (bus.resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_idle[%0d]: resp_valid got %b want 0", c, bus.resp_valid);
            end
            if (c < 7) accepts += $countones(bus.req_ready & bus.req_valid);
`ifdef POW2_ARB_PERF_EN
            if (c == 8) begin
                vectors++;
                if (perf_stall_cnt !== 32'd5) begin
                    miscompares++;
                    $display("FAIL bp_perf_stall: got %0d want 5", perf_stall_cnt);
                end
            end
`endif
            pending = pending & ~(bus.req_ready & bus.req_valid);
            next_cycle();
        end
        vectors++;
        if (accepts !== 2) begin
            miscompares++;
            $display("FAIL bp_accepts: got %0d want 2", accepts);
        end
`ifdef POW2_ARB_PERF_EN
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (perf_grant_cnt[i] !== 32'd1) begin
                miscompares++;
                $display("FAIL bp_perf_grant[%0d]: got %0d want 1", i, perf_grant_cnt[i]);
            end
        end
`endif
        bus.req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b1111;
        next_cycle();
        next_cycle();
        #1;
        vectors++;
        if (bus.resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_prefill: resp_valid got %b want 1", bus.resp_valid);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.resp_valid, bus.req_ready} !== 5'b0) begin
            miscompares++;
            $display("FAIL mid_async: got resp_valid=%b req_ready=%b want 0 0000",
                     bus.resp_valid, bus.req_ready);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (bus.resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_ghost[%0d]: resp_valid got %b want 0", c, bus.resp_valid);
            end
            next_cycle();
        end
        bus.req_valid = 4'b1111;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_pointer: got %b want 0001", bus.req_ready);
        end
        bus.req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_lut_sweep();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pow2_lut_arbiter.md
Name: pow2_lut_arbiter

Overview:
- Shares one Pow2LUT_4x5 instance between NUM_REQ requesters.
  - The LUT is the combinational 4-bit log-fraction to 5-bit linear-fraction converter.
- Round-robin grant, 2-stage pipeline, per-requester valid/ready on the input side, a single tagged response stream on the output side.
- Sits in the log-number unit, in front of log-to-linear conversion, so multiple PE lanes can reuse one conversion table.

Parameters:
- NUM_REQ, 4, number of requesters (1..16).
- TAG_BITS, 8, opaque sideband passed through untouched (e.g. the integer exponent).
- ID_BITS, derived, max(1, $clog2(NUM_REQ)); localparam, not overridable.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_frac  in  NUM_REQ x 4  log fraction per requester.
- req_tag  in  NUM_REQ x TAG_BITS  sideband per requester.
- resp_valid  out  1  response valid.
- resp_ready  in  1  downstream accept.
- resp_id  out  ID_BITS  index of the requester that owns the response.
- resp_lin  out  5  LUT output for the accepted fraction.
- resp_tag  out  TAG_BITS  sideband of the accepted request.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - s1_valid = s2_valid = 0; RR pointer = 0, so requester 0 has highest priority.
  - resp_valid, resp_id, resp_lin, resp_tag all 0; req_ready all 0.
- Stage advance rules:
  - s2_en = !s2_valid | resp_ready.
  - s1_en = !s1_valid | s2_en.
- Grant:
  - When s1_en, req_ready[i] = 1 for the first i with req_valid[i] high, searching from the pointer upward with wrap.
  - req_ready is combinational from req_valid, the pointer and s1_en.
  - req_ready does not depend on resp_ready except through s1_en.
- Accept = req_valid[i] & req_ready[i].
  - On accept, s1 loads {frac, tag, id = i}.
  - Pointer moves to (i+1) mod NUM_REQ.
  - No accept means the pointer holds.
- Stage 1 to stage 2: on s2_en, s2 loads {LUT(s1.frac), s1.tag, s1.id} and s2_valid <= s1_valid.
  - On s1_en with no accept, s1_valid <= 0.
- Outputs are registered from s2; resp_* stay stable while resp_valid & !resp_ready.
- Latency: accept in cycle N gives resp_valid in N+2 when there is no backpressure.
- Throughput: 1 request per cycle sustained.
- Backpressure: with resp_ready low and both stages full, all req_ready go 0. No request is ever dropped or duplicated.
- Simultaneous events:
  - Response drain and new accept happen in the same cycle; the pipeline moves up.
  - If all NUM_REQ requesters are valid continuously, each is granted exactly once per NUM_REQ accepts.
- A requester dropping req_valid without a handshake is legal; the grant moves on.
- NUM_REQ=1: the pointer is constant 0 and ID_BITS=1, resp_id=0.
- Reset mid-operation: in-flight entries are discarded and no response is emitted for them.

Optional Feature:
- POW2_ARB_PERF_EN defined adds these outputs:
  - perf_grant_cnt (NUM_REQ x 32): per-requester accepted count.
  - perf_stall_cnt (32): cycles with resp_valid & !resp_ready.
  - Counters wrap at 2^32 and reset to 0 on reset.
- Undefined: those ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Package pow2_arb_pkg holds:
  - LOG_FRAC_BITS=4 and LIN_FRAC_BITS=5.
  - A function computing ID_BITS.
  - Packed struct typedef pipe_entry_t {frac/lin, tag, id}, parameterised through the package's TAG_BITS default.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: request vector, enable.
  - Outputs: one-hot grant, encoded index.
  - Owns the pointer register.
  - Reused elsewhere for other shared tables.
- Instantiates Pow2LUT_4x5 unchanged, between s1 and s2.

Test Plan:
- Single request: requester 2 sends frac=4'b0010, tag=8'hA5. Expect resp_valid 2 cycles later with resp_lin=5'b00011, resp_id=2, resp_tag=8'hA5.
- Full LUT sweep from requester 0, one frac per cycle 0..15, resp_ready=1. Expect back-to-back responses in order:
  - 00000, 00001, 00011, 00100, 00110, 01000, 01001, 01011,
  - 01101, 01111, 10001, 10100, 10110, 11000, 11011, 11101.
- Fairness: all 4 requesters valid for 12 accepts from reset. Expect grant order 0,1,2,3,0,1,2,3,0,1,2,3, each requester's count = 3.
- Backpressure: hold resp_ready=0 for 5 cycles with 4 requests pending. Expect:
  - exactly 2 accepts, then req_ready=0;
  - resp_* stable throughout;
  - on release, responses drain in order with no loss.
- Reset mid-flight: assert reset with both stages valid. Expect immediately resp_valid=0 and req_ready=0, and pointer=0 after deassert.
- With POW2_ARB_PERF_EN defined: the backpressure scenario gives perf_stall_cnt=5 (counted while resp_valid is high and resp_ready low), and perf_grant_cnt matches the accept counts.
